// File: rtl/instruction_fetch_buffer.sv
// ============================================================================
// Module   : instruction_fetch_buffer
// Purpose  : In-order instruction fetch queue between the PC and decode.
//            Optional macro IFB_BYPASS_EN enables response-to-decode bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PCResult,
  output logic              PCStall,
  input  logic              Flush,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemReady,
  input  logic              MemRespValid,
  input  logic [DATA_W-1:0] MemRespData,
  output logic              InstrValid,
  output logic [DATA_W-1:0] Instruction,
  output logic [ADDR_W-1:0] InstrPC,
  input  logic              InstrReady
);

  localparam int                 C_IDX_W   = $clog2(DEPTH);
  localparam int                 C_PTR_W   = C_IDX_W + 1;
  localparam logic [C_PTR_W-1:0] C_DEPTH   = C_PTR_W'(DEPTH);
  localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);

  logic [C_PTR_W-1:0] r_alloc, r_fill, r_rd, r_discard;
  logic [ADDR_W-1:0]  r_pc   [DEPTH];
  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [DEPTH-1:0]   r_filled;
  logic               r_instr_valid;
  logic [DATA_W-1:0]  r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;

  logic               w_mem_req, w_issue, w_resp_acc, w_pop, w_instr_valid;
  logic [C_PTR_W-1:0] w_occ, w_alloc_nxt, w_fill_nxt, w_rd_nxt;
  logic [C_PTR_W-1:0] w_flush_sum, w_discard_flush;
  logic [C_IDX_W-1:0] w_alloc_idx, w_fill_idx, w_head_idx;
  logic               w_head_filled;
  logic [DATA_W-1:0]  w_head_data;
  logic [ADDR_W-1:0]  w_head_pc;

  assign w_occ      = r_alloc - r_rd;
  assign w_mem_req  = Reset & ~Flush & (w_occ < C_DEPTH) & (r_discard == '0);
  assign w_issue    = w_mem_req & MemReady;
  // Responses with nothing outstanding are protocol errors and are ignored.
  assign w_resp_acc = MemRespValid & ~Flush & (r_discard == '0) & (r_fill != r_alloc);
  assign w_pop      = w_instr_valid & InstrReady & ~Flush;

  assign w_alloc_nxt = r_alloc + C_PTR_W'(w_issue);
  assign w_fill_nxt  = r_fill  + C_PTR_W'(w_resp_acc);
  assign w_rd_nxt    = r_rd    + C_PTR_W'(w_pop);

  assign w_alloc_idx = r_alloc[C_IDX_W-1:0];
  assign w_fill_idx  = r_fill[C_IDX_W-1:0];
  assign w_head_idx  = w_rd_nxt[C_IDX_W-1:0];

  // Next head view, forwarding this cycle's writes into the head slot.
  assign w_head_filled = (w_resp_acc && (w_fill_idx == w_head_idx)) ||
                         (r_filled[w_head_idx] && !(w_issue && (w_alloc_idx == w_head_idx)));
  assign w_head_data   = (w_resp_acc && (w_fill_idx == w_head_idx)) ? MemRespData : r_data[w_head_idx];
  assign w_head_pc     = (w_issue && (w_alloc_idx == w_head_idx)) ? PCResult : r_pc[w_head_idx];

  // Only one of discard / outstanding can be nonzero, so the sum fits the pointer width.
  assign w_flush_sum     = r_discard + (r_alloc - r_fill);
  assign w_discard_flush = (MemRespValid && (w_flush_sum != '0)) ? (w_flush_sum - C_PTR_ONE) : w_flush_sum;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_alloc       <= '0;
      r_fill        <= '0;
      r_rd          <= '0;
      r_discard     <= '0;
      r_filled      <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else if (Flush) begin
      r_alloc       <= '0;
      r_fill        <= '0;
      r_rd          <= '0;
      r_filled      <= '0;
      r_instr_valid <= 1'b0;
      r_discard     <= w_discard_flush;
    end else begin
      r_alloc <= w_alloc_nxt;
      r_fill  <= w_fill_nxt;
      r_rd    <= w_rd_nxt;
      if ((r_discard != '0) && MemRespValid)
        r_discard <= r_discard - C_PTR_ONE;
      if (w_issue)
        r_filled[w_alloc_idx] <= 1'b0;
      if (w_resp_acc)
        r_filled[w_fill_idx] <= 1'b1;
      r_instr_valid <= (w_rd_nxt != w_fill_nxt) && w_head_filled;
      r_instr       <= w_head_data;
      r_instr_pc    <= w_head_pc;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_issue)
      r_pc[w_alloc_idx] <= PCResult;
    if (w_resp_acc)
      r_data[w_fill_idx] <= MemRespData;
  end

  assign MemReq  = w_mem_req;
  assign MemAddr = PCResult;
  assign PCStall = ~w_issue;

`ifdef IFB_BYPASS_EN
  logic w_bypass;
  // Empty buffer and the response lands in the head slot: present it directly.
  assign w_bypass      = w_resp_acc & (r_fill == r_rd);
  assign w_instr_valid = r_instr_valid | w_bypass;
  assign Instruction   = w_bypass ? MemRespData : r_instr;
  assign InstrPC       = w_bypass ? r_pc[r_rd[C_IDX_W-1:0]] : r_instr_pc;
`else
  assign w_instr_valid = r_instr_valid;
  assign Instruction   = r_instr;
  assign InstrPC       = r_instr_pc;
`endif
  assign InstrValid = w_instr_valid;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_buffer.sv
// ============================================================================
// Module   : tb_instruction_fetch_buffer
// Purpose  : Directed self-checking bench for instruction_fetch_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_buffer;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCResult;
  logic        PCStall;
  logic        Flush;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemReady;
  logic        MemRespValid;
  logic [31:0] MemRespData;
  logic        InstrValid;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic        InstrReady;

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  bit mem_auto = 0;
  bit pc_auto  = 0;

  instruction_fetch_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCResult     (PCResult),
    .PCStall      (PCStall),
    .Flush        (Flush),
    .MemReq       (MemReq),
    .MemAddr      (MemAddr),
    .MemReady     (MemReady),
    .MemRespValid (MemRespValid),
    .MemRespData  (MemRespData),
    .InstrValid   (InstrValid),
    .Instruction  (Instruction),
    .InstrPC      (InstrPC),
    .InstrReady   (InstrReady)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h1300_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory answers accepted requests with 1-cycle latency, PC advances on acceptance.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = MemReq & MemReady;
    a   = MemAddr;
    @(posedge Clk);
    #1;
    if (acc) n_acc++;
    if (mem_auto) begin
      MemRespValid = acc;
      MemRespData  = mem_word(a);
    end
    if (pc_auto && acc) PCResult = PCResult + 32'd4;
    #1;
  endtask

  task automatic do_reset();
    Reset        = 1'b0;
    Flush        = 1'b0;
    MemReady     = 1'b1;
    MemRespValid = 1'b0;
    MemRespData  = '0;
    InstrReady   = 1'b1;
    mem_auto     = 0;
    pc_auto      = 0;
    n_acc        = 0;
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset        = 1'b0;
    PCResult     = 32'h40;
    Flush        = 1'b0;
    MemReady     = 1'b1;
    MemRespValid = 1'b0;
    MemRespData  = '0;
    InstrReady   = 1'b1;

    // Reset held for 3 cycles
    repeat (3) @(posedge Clk);
    #2;
    chk("rst_memreq",  32'(MemReq), 32'd0);
    chk("rst_pcstall", 32'(PCStall), 32'd1);
    chk("rst_ivalid",  32'(InstrValid), 32'd0);
    chk("rst_ipc",     InstrPC, 32'd0);
    chk("rst_instr",   Instruction, 32'd0);
    Reset = 1'b1;
    #1;
    chk("rel_memreq",  32'(MemReq), 32'd1);
    chk("rel_memaddr", MemAddr, 32'h40);
    chk("rel_pcstall", 32'(PCStall), 32'd0);

    // Streaming: one instruction per cycle
    PCResult = 32'h0;
    mem_auto = 1;
    pc_auto  = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("str_ivalid",  32'(InstrValid), 32'd1);
      chk("str_ipc",     InstrPC, 32'(4 * k));
      chk("str_instr",   Instruction, mem_word(32'(4 * k)));
      chk("str_pcstall", 32'(PCStall), 32'd0);
    end

    // Backpressure fills the ring, then drains
    do_reset();
    PCResult   = 32'h0;
    InstrReady = 1'b0;
    mem_auto   = 1;
    pc_auto    = 1;
    repeat (8) tick();
    chk("full_nacc",    32'(n_acc), 32'd4);
    chk("full_memreq",  32'(MemReq), 32'd0);
    chk("full_pcstall", 32'(PCStall), 32'd1);
    chk("full_ivalid",  32'(InstrValid), 32'd1);
    chk("full_ipc",     InstrPC, 32'h0);
    chk("full_instr",   Instruction, mem_word(32'h0));
    InstrReady = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("drain_ipc",   InstrPC, 32'(4 * i));
      chk("drain_instr", Instruction, mem_word(32'(4 * i)));
      if (i == 1) begin
        chk("resume_memreq",  32'(MemReq), 32'd1);
        chk("resume_memaddr", MemAddr, 32'd16);
      end
      if (i == 2) chk("resume_nacc", 32'(n_acc), 32'd5);
    end
    tick();
    chk("resume_ivalid", 32'(InstrValid), 32'd1);
    chk("resume_ipc",    InstrPC, 32'd16);

    // Flush with two requests in flight
    do_reset();
    PCResult = 32'h20;
    pc_auto  = 1;
    tick();
    tick();
    pc_auto  = 0;
    Flush    = 1'b1;
    PCResult = 32'h100;
    #1;
    chk("fl_memreq",  32'(MemReq), 32'd0);
    chk("fl_pcstall", 32'(PCStall), 32'd1);
    tick();
    Flush = 1'b0;
    #1;
    chk("fl_d2_memreq", 32'(MemReq), 32'd0);
    chk("fl_d2_ivalid", 32'(InstrValid), 32'd0);
    MemRespValid = 1'b1;
    MemRespData  = 32'hBAD0;
    tick();
    chk("fl_d1_memreq", 32'(MemReq), 32'd0);
    chk("fl_d1_ivalid", 32'(InstrValid), 32'd0);
    MemRespData = 32'hBAD1;
    tick();
    MemRespValid = 1'b0;
    #1;
    chk("fl_d0_memreq",  32'(MemReq), 32'd1);
    chk("fl_d0_memaddr", MemAddr, 32'h100);
    mem_auto = 1;
    pc_auto  = 1;
    tick();
    tick();
    chk("fl_new_ivalid", 32'(InstrValid), 32'd1);
    chk("fl_new_ipc",    InstrPC, 32'h100);
    chk("fl_new_instr",  Instruction, mem_word(32'h100));

    // Flush coinciding with a response and a pop
    do_reset();
    InstrReady = 1'b0;
    PCResult   = 32'h0;
    pc_auto    = 1;
    tick();
    MemRespValid = 1'b1;
    MemRespData  = 32'h1111_0000;
    tick();
    MemRespValid = 1'b0;
    tick();
    chk("frp_ivalid", 32'(InstrValid), 32'd1);
    chk("frp_ipc",    InstrPC, 32'h0);
    chk("frp_instr",  Instruction, 32'h1111_0000);
    pc_auto      = 0;
    InstrReady   = 1'b1;
    Flush        = 1'b1;
    MemRespValid = 1'b1;
    MemRespData  = 32'h2222_0000;
    PCResult     = 32'h200;
    #1;
    chk("frp_memreq",  32'(MemReq), 32'd0);
    chk("frp_pcstall", 32'(PCStall), 32'd1);
    tick();
    Flush        = 1'b0;
    MemRespValid = 1'b0;
    #1;
    chk("frp_d1_ivalid", 32'(InstrValid), 32'd0);
    chk("frp_d1_memreq", 32'(MemReq), 32'd0);
    MemRespValid = 1'b1;
    MemRespData  = 32'h3333_0000;
    tick();
    MemRespValid = 1'b0;
    #1;
    chk("frp_d0_memreq",  32'(MemReq), 32'd1);
    chk("frp_d0_memaddr", MemAddr, 32'h200);
    chk("frp_d0_ivalid",  32'(InstrValid), 32'd0);

    // Response-to-decode latency from an empty buffer
    do_reset();
    PCResult = 32'h80;
    tick();
    MemReady     = 1'b0;
    MemRespValid = 1'b1;
    MemRespData  = 32'hDEADBEEF;
    #1;
`ifdef IFB_BYPASS_EN
    chk("lat_n_ivalid", 32'(InstrValid), 32'd1);
    chk("lat_n_instr",  Instruction, 32'hDEADBEEF);
    chk("lat_n_ipc",    InstrPC, 32'h80);
`else
    chk("lat_n_ivalid", 32'(InstrValid), 32'd0);
`endif
    tick();
    MemRespValid = 1'b0;
    #1;
`ifdef IFB_BYPASS_EN
    chk("lat_n1_ivalid", 32'(InstrValid), 32'd0);
`else
    chk("lat_n1_ivalid", 32'(InstrValid), 32'd1);
    chk("lat_n1_instr",  Instruction, 32'hDEADBEEF);
    chk("lat_n1_ipc",    InstrPC, 32'h80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
